reg_scoreboard: RTL and testbench
=================================

// Module: reg_scoreboard
// PURPOSE
//   Producer-side companion to the EX-stage forwarding mux. Tracks every in-flight
//   destination register and stalls ID until each source operand can be bypassed.
//   Forwarding handles only results that already exist; this block holds issue
//   until the result exists.
//   Sits between ID (issue/query) and WB (retire). Drives the pipeline stall.
// PARAMETERS
//   NREG   32  architectural registers; x0 is hardwired zero and never tracked
//   LAT_W  3   width of the per-register latency countdown (max latency 7)
// PORTS
//   clk         in   1      system clock, rising edge
//   rst_n       in   1      asynchronous reset, active-low
//   rs1_id      in   5      ID-stage source 1 index
//   rs2_id      in   5      ID-stage source 2 index
//   issue_valid in   1      ID presents an instruction this cycle
//   issue_we    in   1      instruction writes rd
//   issue_rd    in   5      destination index
//   issue_lat   in   LAT_W  cycles after issue until the result is forwardable (0 = next EX)
//   wb_valid    in   1      WB retires a register write this cycle
//   wb_rd       in   5      retired destination index
//   stall       out  1      hold PC/IF/ID and insert a bubble into EX (combinational)
//   busy_vec    out  NREG   registered busy bit per register; bit 0 always 0
//   busy_cnt    out  6      registered count of set busy bits (0..31)
// BEHAVIOUR
//   State: busy[r] and cnt[r] (LAT_W bits) for r = 1..31.
//   Reset (async, rst_n=0): all busy=0, cnt=0, busy_vec=0, busy_cnt=0. stall therefore
//     reads 0. Reset mid-operation discards all pending entries immediately.
//   ready[r] = busy[r] & (cnt[r]==0): the result is in MEM/WB and forwardable.
//   raw_hit  = for s in {rs1_id, rs2_id}: s!=0 & busy[s] & cnt[s]!=0.
//   waw_hit  = issue_we & issue_rd!=0 & busy[issue_rd] & cnt[issue_rd] > issue_lat
//     (a younger write must not complete before an older one).
//   stall = issue_valid & (raw_hit | waw_hit). The block does not gate RAW on whether
//     the instruction actually reads rs1/rs2; it stalls conservatively.
//   accept = issue_valid & ~stall & issue_we & issue_rd!=0.
//   Per clock edge, for each r (priority high->low):
//     1. accept & issue_rd==r: busy<=1, cnt<=issue_lat. This wins over a same-cycle
//        wb_rd==r retire of an older write.
//     2. wb_valid & wb_rd==r: busy<=0, cnt<=0.
//     3. busy & cnt!=0: cnt<=cnt-1. The counter saturates at 0 and never wraps.
//   wb_rd==0, or wb on a register that is not busy: no effect.
//   busy_cnt: +1 on accept to a non-busy rd. -1 on a retire that clears a busy bit.
//     A simultaneous accept of a non-busy rd and a clearing retire on another rd
//     leaves it unchanged. A same-rd accept+retire leaves it unchanged.
//     Invariant: busy_cnt == popcount(busy_vec).
//   Latency: issue at edge N -> busy_vec visible after N. A stall on a dependent read
//     clears in the cycle in which cnt reaches 0, i.e. issue_lat cycles after issue.
//   A stall decision is purely combinational and uses the current state only. The
//     stalled instruction re-presents and is re-evaluated every cycle.
// TESTING
//   1 Load-use: issue rd=5 lat=2. Next cycle rs1_id=5 -> stall=1 for 2 cycles, then 0.
//     busy_vec[5]=1 until wb_rd=5.
//   2 Zero-latency ALU: issue rd=7 lat=0. Next cycle rs2_id=7 -> stall=0 (forward path).
//   3 x0: issue rd=0 lat=3 -> busy_vec=0, busy_cnt=0. rs1_id=0 never stalls.
//   4 Same-rd collision: wb_rd=9 and accept rd=9 lat=1 in one cycle -> busy_vec[9]=1,
//     cnt=1, busy_cnt unchanged.
//   5 WAW: rd=3 busy with cnt=4, issue rd=3 lat=1 -> stall=1 until cnt<=1, then accept.
//   6 Fill and drain: issue rd=1..31 with lat=7 back to back -> busy_cnt=31. Retire all ->
//     busy_cnt=0. Assert rst_n=0 midway -> all outputs 0 at once.

Source files
------------

// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - issue/retire/stall bundle between ID, WB and the scoreboard
// Purpose: groups the ID query/issue, WB retire and scoreboard status signals.
// Ports (master = pipeline side, slave = scoreboard):
//   rs1_id, rs2_id              ID source indices
//   issue_valid, issue_we       ID presents an instruction / it writes rd
//   issue_rd, issue_lat         destination index and result latency
//   wb_valid, wb_rd             WB retire strobe and index
//   stall                       combinational pipeline hold
//   busy_vec, busy_cnt          registered busy bits and their population count
interface reg_scoreboard_if #(
  parameter int NREG  = 32,
  parameter int LAT_W = 3
);
  logic [4:0]       rs1_id;
  logic [4:0]       rs2_id;
  logic             issue_valid;
  logic             issue_we;
  logic [4:0]       issue_rd;
  logic [LAT_W-1:0] issue_lat;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             stall;
  logic [NREG-1:0]  busy_vec;
  logic [5:0]       busy_cnt;

  modport master (
    output rs1_id, rs2_id, issue_valid, issue_we, issue_rd, issue_lat, wb_valid, wb_rd,
    input  stall, busy_vec, busy_cnt
  );

  modport slave (
    input  rs1_id, rs2_id, issue_valid, issue_we, issue_rd, issue_lat, wb_valid, wb_rd,
    output stall, busy_vec, busy_cnt
  );
endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - in-flight destination tracker that stalls ID until operands are forwardable
// Purpose: holds issue while a source (RAW) or destination (WAW) has a result that
//   does not yet exist; the forwarding mux covers everything else.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   sb      reg_scoreboard_if.slave: issue/query and retire inputs, stall,
//           busy_vec and busy_cnt outputs
module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int LAT_W = 3
) (
  input logic            clk,
  input logic            rst_n,
  reg_scoreboard_if.slave sb
);

  logic [NREG-1:0]  busy;
  logic [LAT_W-1:0] cnt [NREG];
  logic [5:0]       busy_cnt_q;

  logic raw_hit;
  logic waw_hit;
  logic stall;
  logic accept;
  logic cnt_inc;
  logic cnt_dec;

  // A source is only a hazard while its countdown is running; cnt==0 means the
  // value already sits in MEM/WB and the forwarding mux can supply it.
  always_comb begin
    raw_hit = 1'b0;
    if (sb.rs1_id != 5'd0 && busy[sb.rs1_id] && cnt[sb.rs1_id] != '0) raw_hit = 1'b1;
    if (sb.rs2_id != 5'd0 && busy[sb.rs2_id] && cnt[sb.rs2_id] != '0) raw_hit = 1'b1;

    // Younger write may not finish before the older one to the same register.
    waw_hit = sb.issue_we && sb.issue_rd != 5'd0 && busy[sb.issue_rd] &&
              (cnt[sb.issue_rd] > sb.issue_lat);

    stall  = sb.issue_valid && (raw_hit || waw_hit);
    accept = sb.issue_valid && !stall && sb.issue_we && sb.issue_rd != 5'd0;

    cnt_inc = accept && !busy[sb.issue_rd];
    // A retire overridden by a same-register accept does not clear the bit.
    cnt_dec = sb.wb_valid && sb.wb_rd != 5'd0 && busy[sb.wb_rd] &&
              !(accept && sb.issue_rd == sb.wb_rd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      busy_cnt_q <= '0;
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      // Entry 0 is never written, so x0 stays untracked.
      for (int r = 1; r < NREG; r++) begin
        if (accept && sb.issue_rd == 5'(r)) begin
          busy[r] <= 1'b1;
          cnt[r]  <= sb.issue_lat;
        end else if (sb.wb_valid && sb.wb_rd == 5'(r)) begin
          busy[r] <= 1'b0;
          cnt[r]  <= '0;
        end else if (busy[r] && cnt[r] != '0) begin
          cnt[r] <= cnt[r] - LAT_W'(1);
        end
      end

      case ({cnt_inc, cnt_dec})
        2'b10:   busy_cnt_q <= busy_cnt_q + 6'd1;
        2'b01:   busy_cnt_q <= busy_cnt_q - 6'd1;
        default: busy_cnt_q <= busy_cnt_q;
      endcase
    end
  end

  assign sb.stall    = stall;
  assign sb.busy_vec = busy;
  assign sb.busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - self-checking bench for reg_scoreboard
module tb_reg_scoreboard;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_scoreboard_if #(.NREG(32), .LAT_W(3)) sbif ();

  reg_scoreboard #(.NREG(32), .LAT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sbif)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per register, is a write pending and how many cycles remain.
  bit m_busy [32];
  int m_left [32];

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       iv;
    logic       we;
    logic [4:0] rd;
    logic [2:0] lat;
    logic       wbv;
    logic [4:0] wrd;
    logic       exp_stall;
    int         exp_cnt;
  } vec_t;

  vec_t tbl [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      m_busy[r] = 1'b0;
      m_left[r] = 0;
    end
  endtask

  function automatic bit pending(input int r);
    return r != 0 && m_busy[r] && m_left[r] > 0;
  endfunction

  function automatic bit model_stall(input int r1, input int r2, input bit iv, input bit we,
                                     input int rd, input int lat);
    bit waw;
    waw = we && rd != 0 && m_busy[rd] && m_left[rd] > lat;
    return iv && (pending(r1) || pending(r2) || waw);
  endfunction

  function automatic logic [31:0] model_vec();
    logic [31:0] v;
    v = '0;
    for (int r = 1; r < 32; r++) v[r] = m_busy[r];
    return v;
  endfunction

  function automatic int model_pop();
    int n;
    n = 0;
    for (int r = 1; r < 32; r++) n += m_busy[r] ? 1 : 0;
    return n;
  endfunction

  // Called just after a negedge; leaves the bench just after the next negedge.
  task automatic step(input logic [4:0] r1, input logic [4:0] r2, input logic iv, input logic we,
                      input logic [4:0] rd, input logic [2:0] lat, input logic wbv,
                      input logic [4:0] wrd, output logic s_o, output logic [5:0] c_o);
    bit ms;
    bit acc;
    sbif.rs1_id = r1; sbif.rs2_id = r2;
    sbif.issue_valid = iv; sbif.issue_we = we;
    sbif.issue_rd = rd; sbif.issue_lat = lat;
    sbif.wb_valid = wbv; sbif.wb_rd = wrd;
    #1;
    ms = model_stall(int'(r1), int'(r2), iv, we, int'(rd), int'(lat));
    s_o = sbif.stall;
    check("stall_model", {31'd0, sbif.stall}, {31'd0, ms});
    @(posedge clk);
    acc = iv && !ms && we && rd != 0;
    for (int r = 1; r < 32; r++) begin
      if (acc && int'(rd) == r) begin
        m_busy[r] = 1'b1;
        m_left[r] = int'(lat);
      end else if (wbv && int'(wrd) == r) begin
        m_busy[r] = 1'b0;
        m_left[r] = 0;
      end else if (m_left[r] > 0) begin
        m_left[r]--;
      end
    end
    #1;
    c_o = sbif.busy_cnt;
    check("busy_vec_model", sbif.busy_vec, model_vec());
    check("busy_cnt_model", {26'd0, sbif.busy_cnt}, 32'(model_pop()));
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    sbif.rs1_id = '0; sbif.rs2_id = '0;
    sbif.issue_valid = 1'b0; sbif.issue_we = 1'b0;
    sbif.issue_rd = '0; sbif.issue_lat = '0;
    sbif.wb_valid = 1'b0; sbif.wb_rd = '0;
  endtask

  logic       s;
  logic [5:0] c;

  initial begin
    //            rs1 rs2 iv we rd lat wbv wrd  stall cnt
    tbl[0]  = '{5'd0, 5'd0, 1, 1, 5'd5, 3'd2, 0, 5'd0,  0, 1};  // load-use issue
    tbl[1]  = '{5'd5, 5'd0, 1, 0, 5'd0, 3'd0, 0, 5'd0,  1, 1};
    tbl[2]  = '{5'd5, 5'd0, 1, 0, 5'd0, 3'd0, 0, 5'd0,  1, 1};
    tbl[3]  = '{5'd5, 5'd0, 1, 0, 5'd0, 3'd0, 0, 5'd0,  0, 1};
    tbl[4]  = '{5'd0, 5'd0, 0, 0, 5'd0, 3'd0, 1, 5'd5,  0, 0};
    tbl[5]  = '{5'd0, 5'd0, 1, 1, 5'd7, 3'd0, 0, 5'd0,  0, 1};  // zero-latency ALU
    tbl[6]  = '{5'd0, 5'd7, 1, 0, 5'd0, 3'd0, 0, 5'd0,  0, 1};
    tbl[7]  = '{5'd0, 5'd0, 0, 0, 5'd0, 3'd0, 1, 5'd7,  0, 0};
    tbl[8]  = '{5'd0, 5'd0, 1, 1, 5'd0, 3'd3, 0, 5'd0,  0, 0};  // x0 write ignored
    tbl[9]  = '{5'd0, 5'd0, 1, 0, 5'd0, 3'd0, 1, 5'd0,  0, 0};
    tbl[10] = '{5'd0, 5'd0, 1, 1, 5'd9, 3'd0, 0, 5'd0,  0, 1};  // same-rd collision
    tbl[11] = '{5'd0, 5'd0, 1, 1, 5'd9, 3'd1, 1, 5'd9,  0, 1};
    tbl[12] = '{5'd9, 5'd0, 1, 0, 5'd0, 3'd0, 0, 5'd0,  1, 1};
    tbl[13] = '{5'd0, 5'd0, 0, 0, 5'd0, 3'd0, 1, 5'd9,  0, 0};
    tbl[14] = '{5'd0, 5'd0, 1, 1, 5'd3, 3'd4, 0, 5'd0,  0, 1};  // WAW
    tbl[15] = '{5'd0, 5'd0, 1, 1, 5'd3, 3'd1, 0, 5'd0,  1, 1};
    tbl[16] = '{5'd0, 5'd0, 1, 1, 5'd3, 3'd1, 0, 5'd0,  1, 1};
    tbl[17] = '{5'd0, 5'd0, 1, 1, 5'd3, 3'd1, 0, 5'd0,  1, 1};
    tbl[18] = '{5'd0, 5'd0, 1, 1, 5'd3, 3'd1, 0, 5'd0,  0, 1};
    tbl[19] = '{5'd0, 5'd0, 0, 0, 5'd0, 3'd0, 1, 5'd3,  0, 0};
    tbl[20] = '{5'd0, 5'd0, 0, 0, 5'd0, 3'd0, 1, 5'd12, 0, 0};  // retire of idle reg

    idle_inputs();
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check("reset_busy_vec", sbif.busy_vec, 32'd0);
    check("reset_busy_cnt", {26'd0, sbif.busy_cnt}, 32'd0);
    check("reset_stall", {31'd0, sbif.stall}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].rs1, tbl[i].rs2, tbl[i].iv, tbl[i].we, tbl[i].rd, tbl[i].lat,
           tbl[i].wbv, tbl[i].wrd, s, c);
      check($sformatf("tbl%0d_stall", i), {31'd0, s}, {31'd0, tbl[i].exp_stall});
      check($sformatf("tbl%0d_cnt", i), {26'd0, c}, 32'(tbl[i].exp_cnt));
    end

    // Fill every register with the longest latency, then drain.
    for (int r = 1; r < 32; r++) step(5'd0, 5'd0, 1, 1, 5'(r), 3'd7, 0, 5'd0, s, c);
    check("fill_busy_cnt", {26'd0, sbif.busy_cnt}, 32'd31);
    check("fill_busy_vec", sbif.busy_vec, 32'hFFFF_FFFE);
    for (int r = 1; r < 32; r++) step(5'd0, 5'd0, 0, 0, 5'd0, 3'd0, 1, 5'(r), s, c);
    check("drain_busy_cnt", {26'd0, sbif.busy_cnt}, 32'd0);

    // Refill partway, then reset asynchronously mid-cycle while a hazard is presented.
    for (int r = 1; r < 16; r++) step(5'd0, 5'd0, 1, 1, 5'(r), 3'd7, 0, 5'd0, s, c);
    sbif.rs1_id = 5'd15; sbif.issue_valid = 1'b1; sbif.issue_we = 1'b0;
    #1;
    check("pre_reset_stall", {31'd0, sbif.stall}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_busy_vec", sbif.busy_vec, 32'd0);
    check("midreset_busy_cnt", {26'd0, sbif.busy_cnt}, 32'd0);
    check("midreset_stall", {31'd0, sbif.stall}, 32'd0);
    model_clear();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random traffic over a small register window so hazards are frequent.
    for (int i = 0; i < 1500; i++) begin
      step(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), s, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
